// File: rtl/lou_op_sequencer.sv
// -----------------------------------------------------------------------------
// lou_op_sequencer
//
// Request-buffering front end for the logical operations unit (LOU).
// Requests (opcode plus two operands) arrive on a valid/ready handshake and
// are queued in a small FIFO. One request per cycle is presented to the
// combinational LOU from the FIFO head. The LOU result is captured into a
// single registered result slot that has its own valid/ready handshake.
// Opcodes above 4'b0101 are unsupported: their result is forced to 8'h00 and
// flagged on res_err.
//
// Parameters
//   DEPTH      request FIFO entries (power of two, minimum 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   request present
//   in_ready   FIFO not full
//   in_op      LOU opcode of the request
//   in_a       operand A of the request
//   in_b       operand B of the request
//   lou_op     to the LOU opcode input (FIFO head, 0 when empty)
//   lou_a      to the LOU A input (FIFO head, 0 when empty)
//   lou_b      to the LOU B input (FIFO head, 0 when empty)
//   lou_y      from the LOU Y output (combinational from lou_*)
//   res_valid  result slot full
//   res_ready  consumer accepts the result
//   res_y      captured result
//   res_err    captured request had an unsupported opcode
//   occupancy  FIFO entry count
//   res_tag    push-order tag of the captured request (LOU_SEQ_TAG_EN only)
//
// Optional feature
//   LOU_SEQ_TAG_EN  when defined, every push is stamped with a wrapping tag
//                   counter value and that tag follows the request into the
//                   result slot on res_tag.
// -----------------------------------------------------------------------------
module lou_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    output logic [3:0]                 lou_op,
    output logic [3:0]                 lou_a,
    output logic [3:0]                 lou_b,
    input  logic [7:0]                 lou_y,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_y,
    output logic                       res_err,
`ifdef LOU_SEQ_TAG_EN
    output logic [$clog2(DEPTH):0]     res_tag,
`endif
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]      MAX_OP     = 4'b0101;

    // Result slot states: EMPTY means no result is held, FULL means res_y /
    // res_err hold a result the consumer has not yet taken.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      slot_state;
    slot_state_t      slot_next;

    logic [3:0]       op_mem [DEPTH];
    logic [3:0]       a_mem  [DEPTH];
    logic [3:0]       b_mem  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             fifo_empty;
    logic             push;
    logic             issue;
    logic [3:0]       head_op;
    logic [3:0]       head_a;
    logic [3:0]       head_b;
    logic             head_bad;

`ifdef LOU_SEQ_TAG_EN
    logic [AW:0]      tag_mem [DEPTH];
    logic [AW:0]      tag_cnt;
`endif

    // Handshake and FIFO-head decode. Full and empty come only from the entry
    // count, so the pointers can wrap freely. in_ready deliberately ignores a
    // pop in the same cycle to keep it a pure function of registered state.
    // The LOU inputs are zeroed while the FIFO is empty so the LOU never sees
    // a stale entry.
    always_comb begin
        fifo_empty = (count == '0);
        in_ready   = (count != FULL_COUNT);
        push       = in_valid && in_ready;
        issue      = !fifo_empty && (!res_valid || res_ready);

        head_op    = 4'h0;
        head_a     = 4'h0;
        head_b     = 4'h0;
        if (!fifo_empty) begin
            head_op = op_mem[rd_ptr];
            head_a  = a_mem[rd_ptr];
            head_b  = b_mem[rd_ptr];
        end
        head_bad   = (head_op > MAX_OP);

        lou_op     = head_op;
        lou_a      = head_a;
        lou_b      = head_b;
        occupancy  = count;
    end

    // FIFO storage. Entries are only meaningful while counted, so the array
    // needs no reset; a reset simply discards them by clearing the count.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= in_op;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop advances
    // both pointers and leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_state <= SLOT_EMPTY;
        end else begin
            slot_state <= slot_next;
        end
    end

    // Result slot next-state logic. An issue always leaves the slot full,
    // whether it refills an empty slot or replaces a result being taken in
    // the same cycle. Without an issue, a taken result empties the slot.
    always_comb begin
        slot_next = slot_state;
        res_valid = (slot_state == SLOT_FULL);
        case (slot_state)
            SLOT_EMPTY: begin
                if (issue) begin
                    slot_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (issue) begin
                    slot_next = SLOT_FULL;
                end else if (res_ready) begin
                    slot_next = SLOT_EMPTY;
                end
            end
            default: begin
                slot_next = SLOT_EMPTY;
            end
        endcase
    end

    // Result capture. Unsupported opcodes never expose whatever the LOU
    // produces for them; the slot gets a clean zero plus the error flag.
    // Between issues the captured values hold, which keeps them stable while
    // the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y   <= 8'h00;
            res_err <= 1'b0;
        end else if (issue) begin
            res_y   <= head_bad ? 8'h00 : lou_y;
            res_err <= head_bad;
        end
    end

`ifdef LOU_SEQ_TAG_EN
    // Tag storage written alongside the request fields.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= tag_cnt;
        end
    end

    // Tag counter stamps each accepted push and wraps naturally at its
    // width; the stamped tag travels with the request into the result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt <= '0;
            res_tag <= '0;
        end else begin
            if (push) begin
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (issue) begin
                res_tag <= tag_mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lou_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lou_op_sequencer
//
// Directed testbench for lou_op_sequencer. The bench plays the LOU itself
// (a small combinational function of opcode and operands) and keeps a
// queue-based behavioural model of the sequencer that is compared against the
// DUT on every falling clock edge. Directed sequences add hand-computed
// literal expectations for the single-op, back-to-back, backpressure,
// bad-opcode, reset and pointer-wrap scenarios.
// -----------------------------------------------------------------------------
module tb_lou_op_sequencer;

    localparam int DEPTH = 4;
    localparam int TW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = 4'h0;
    logic [3:0]    in_a = 4'h0;
    logic [3:0]    in_b = 4'h0;
    logic [3:0]    lou_op;
    logic [3:0]    lou_a;
    logic [3:0]    lou_b;
    logic [7:0]    lou_y;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_y;
    logic          res_err;
    logic [TW-1:0] occupancy;
`ifdef LOU_SEQ_TAG_EN
    logic [TW-1:0] res_tag;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]    op;
        logic [3:0]    a;
        logic [3:0]    b;
        logic [TW-1:0] tag;
    } req_t;

    req_t          mq[$];
    logic          m_valid  = 1'b0;
    logic [7:0]    m_y      = 8'h00;
    logic          m_err    = 1'b0;
    logic [TW-1:0] m_tag    = '0;
    logic [TW-1:0] m_tagcnt = '0;

    logic [7:0]    exp_tab [5] = '{8'h07, 8'h14, 8'h23, 8'h3C, 8'h48};

    // Clock generation.
    always #5 clk = ~clk;

    // The LOU as seen by the sequencer: opcodes 0..5 are NAND, NOR, XOR,
    // XNOR, AND, OR; anything else produces a recognisable non-zero value so
    // the sequencer's zero-forcing is visible. The opcode rides in the upper
    // nibble so all eight result bits carry information.
    function automatic logic [7:0] lou_model(input logic [3:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic [3:0] r;
        case (op)
            4'd0:    r = ~(a & b);
            4'd1:    r = ~(a | b);
            4'd2:    r = a ^ b;
            4'd3:    r = ~(a ^ b);
            4'd4:    r = a & b;
            4'd5:    r = a | b;
            default: r = 4'hF;
        endcase
        return {op, r};
    endfunction

    assign lou_y = lou_model(lou_op, lou_a, lou_b);

    lou_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .lou_op    (lou_op),
        .lou_a     (lou_a),
        .lou_b     (lou_b),
        .lou_y     (lou_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_err   (res_err),
`ifdef LOU_SEQ_TAG_EN
        .res_tag   (res_tag),
`endif
        .occupancy (occupancy)
    );

    // One comparison: counts it, and reports a failure on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; they are consumed by the
    // following rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic rr);
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        res_ready = rr;
    endtask

    // Behavioural model: a request queue plus a one-entry result slot,
    // advanced on every rising edge and cleared the moment reset asserts.
    initial begin
        req_t e;
        bit   do_issue;
        bit   do_push;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_valid  = 1'b0;
                m_y      = 8'h00;
                m_err    = 1'b0;
                m_tag    = '0;
                m_tagcnt = '0;
            end else begin
                do_issue = (mq.size() != 0) && (!m_valid || res_ready);
                do_push  = in_valid && (mq.size() != DEPTH);
                if (do_issue) begin
                    e       = mq.pop_front();
                    m_valid = 1'b1;
                    m_err   = (e.op > 4'd5);
                    m_y     = m_err ? 8'h00 : lou_model(e.op, e.a, e.b);
                    m_tag   = e.tag;
                end else if (m_valid && res_ready) begin
                    m_valid = 1'b0;
                end
                if (do_push) begin
                    mq.push_back('{in_op, in_a, in_b, m_tagcnt});
                    m_tagcnt = m_tagcnt + 1'b1;
                end
            end
        end
    end

    // Every falling edge: all DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            checkOutput("model occupancy", 32'(occupancy), 32'(mq.size()));
            checkOutput("model res_valid", 32'(res_valid), 32'(m_valid));
            checkOutput("model res_y", 32'(res_y), 32'(m_y));
            checkOutput("model res_err", 32'(res_err), 32'(m_err));
            if (mq.size() == 0) begin
                checkOutput("model lou_in", {20'h0, lou_op, lou_a, lou_b}, 32'h0);
            end else begin
                checkOutput("model lou_in", {20'h0, lou_op, lou_a, lou_b},
                            {20'h0, mq[0].op, mq[0].a, mq[0].b});
            end
`ifdef LOU_SEQ_TAG_EN
            checkOutput("model res_tag", 32'(res_tag), 32'(m_tag));
`endif
        end
    end

    // Directed sequences with literal expectations.
    initial begin
        // Power-up reset values, checked while reset is still asserted.
        #1;
        checkOutput("reset occupancy", 32'(occupancy), 32'h0);
        checkOutput("reset in_ready", 32'(in_ready), 32'h1);
        checkOutput("reset res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset res_y", 32'(res_y), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single op: NAND of 1010 and 1001 = 0111, one cycle after the push.
        applyStimulus(1'b1, 4'd0, 4'hA, 4'h9, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("single queued occ", 32'(occupancy), 32'h1);
        checkOutput("single not yet valid", 32'(res_valid), 32'h0);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("single res_valid", 32'(res_valid), 32'h1);
        checkOutput("single res_y", 32'(res_y), 32'h07);
        checkOutput("single res_err", 32'(res_err), 32'h0);

        // Back-to-back: ops 0..3 emerge on consecutive cycles.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 4, 4'(i), 4'hA, 4'h9, 1'b1);
            if (i >= 2) begin
                checkOutput("b2b res_valid", 32'(res_valid), 32'h1);
                checkOutput("b2b res_y", 32'(res_y), 32'(exp_tab[i-2]));
            end
        end

        // Backpressure: five pushes with the consumer stalled fill the slot
        // plus all four FIFO entries; a sixth attempt is refused.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'(k), 4'hA, 4'h9, 1'b0);
        end
        applyStimulus(1'b1, 4'd5, 4'hA, 4'h9, 1'b0);
        checkOutput("bp in_ready", 32'(in_ready), 32'h0);
        checkOutput("bp occupancy", 32'(occupancy), 32'h4);
        checkOutput("bp res_valid", 32'(res_valid), 32'h1);
        checkOutput("bp res_y held", 32'(res_y), 32'h07);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        for (int k = 1; k < 5; k++) begin
            applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
            checkOutput("bp drain res_y", 32'(res_y), 32'(exp_tab[k]));
        end
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("bp drained valid", 32'(res_valid), 32'h0);

        // Bad opcode followed by a valid one (OR of 1010 and 1001 = 1011).
        applyStimulus(1'b1, 4'd6, 4'hA, 4'h9, 1'b1);
        applyStimulus(1'b1, 4'd5, 4'hA, 4'h9, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("badop res_y", 32'(res_y), 32'h00);
        checkOutput("badop res_err", 32'(res_err), 32'h1);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("goodop res_err", 32'(res_err), 32'h0);
        checkOutput("goodop res_y", 32'(res_y), 32'h5B);

        // Reset mid-stream with a held result and queued entries.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'd0, 4'hA, 4'h9, 1'b0);
        end
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b0);
        checkOutput("prereset occupancy", 32'(occupancy), 32'h2);
        checkOutput("prereset res_y", 32'(res_y), 32'h07);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset occupancy", 32'(occupancy), 32'h0);
        checkOutput("midreset res_valid", 32'(res_valid), 32'h0);
        checkOutput("midreset res_y", 32'(res_y), 32'h0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'h1);
        checkOutput("midreset lou_op", 32'(lou_op), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Twelve requests stream through four entries: pointers wrap twice,
        // and tags run 0..7 then 0..3.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i < 12, 4'(i % 7), 4'(i), 4'(~i), 1'b1);
            if (i >= 2) begin
                checkOutput("wrap res_valid", 32'(res_valid), 32'h1);
`ifdef LOU_SEQ_TAG_EN
                checkOutput("wrap res_tag", 32'(res_tag), 32'((i - 2) % 8));
`endif
            end
        end
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'h0, 4'h0, 1'b1);
        checkOutput("final occupancy", 32'(occupancy), 32'h0);
        checkOutput("final res_valid", 32'(res_valid), 32'h0);

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
